day18_even_counter: RTL and testbench
=====================================

# day18_even_counter

Free-running even-number counter. Each clock it advances by 2 and wraps modulo 2^WIDTH, so the output only ever holds even values (0, 2, 4, … , 2^WIDTH−2). It is a standalone leaf block used as a simple sequence source and as a counter reference for other blocks. It has no handshake and no enable.

## Interface
- WIDTH, default 4: counter width in bits; legal range 2..32.
- STEP, default 2: increment per cycle; must be even and less than 2^WIDTH.

- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock, asynchronous, active-low.
- count  output  WIDTH  current even count, registered.
- wrap  output  1  wrap pulse; present only when EVEN_COUNTER_WRAP_EN is defined (see Configuration).

## Operation
- rst low: count forced to 0 immediately, independent of clk, and held at 0 while rst stays low.
- rst high: on every rising clk edge, count <= (count + STEP) mod 2^WIDTH.
- Arithmetic is unsigned; the carry out of bit WIDTH−1 is discarded.
- Default sequence is 0, 2, 4, 6, 8, 10, 12, 14, 0, 2, … with a period of 8 cycles, i.e. 2^WIDTH / STEP in general.
- count[0] is constant 0 after reset. It is driven as a tied-0 bit and is not stored.
- Reset mid-count: the asynchronous clear wins. On release, counting resumes from 0 and there is no partial state.
- There are no other control inputs, so no simultaneous-event cases arise beyond reset versus clock, where reset has priority.

## Timing
- Latency: count changes one register delay (clk-to-q) after each rising clk edge.
- First edge with rst high: count goes from 0 to STEP.
- Reset assertion: count = 0 combinationally after the asynchronous clear, with no clock needed.
- Reset release: rst must rise synchronously with respect to clk, meeting recovery and removal. The first increment happens on the first rising edge after release.
- The output is glitch-free and driven directly from flops.

## Configuration
- Macro: EVEN_COUNTER_WRAP_EN.
- Defined:
  - Adds a registered output wrap.
  - wrap is 1 for exactly one cycle, in the same cycle that count becomes 0 because of wrap-around (after 14 → 0 for the defaults).
  - wrap is 0 during reset and on the first cycle after reset release.
- Undefined:
  - The wrap port and its logic are absent.
  - count behaviour is identical in both builds.

## Structure
- Shared package even_counter_pkg holds:
  - DEFAULT_WIDTH = 4 and DEFAULT_STEP = 2.
  - A compile-time check function that rejects an odd STEP, or STEP ≥ 2^WIDTH, through an elaboration-time error.
- No sub-module is needed. A single register plus an adder is the whole datapath.
- The wrap-detect logic stays inline under the macro guard.

## Test plan
- Asynchronous reset: hold rst=0 across several edges -> count=0 throughout. Drop rst to 0 between edges -> count=0 before the next edge.
- Counting: release rst, then apply 8 edges -> count = 2, 4, 6, 8, 10, 12, 14, 0.
- Wrap-around over 16 edges -> the sequence repeats exactly twice, and count[0]=0 on every sample.
- Reset mid-count: at count=10, pull rst low -> count=0 immediately. Release -> next edges give 2, 4.
- Macro build: with EVEN_COUNTER_WRAP_EN defined, run 16 edges -> wrap=1 only in the two cycles where count is 0 after 14, and 0 elsewhere, including after reset release.
- Parameterised build: WIDTH=3, STEP=2 -> 0, 2, 4, 6, 0. WIDTH=5, STEP=4 -> 0, 4, 8, … , 28, 0.

Source files
------------

// File: rtl/even_counter_pkg.sv
// Shared definitions for the even-number counter: default parameters and
// an elaboration-time legality check on WIDTH/STEP.
package even_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_STEP  = 2;

  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 32;

  // True when WIDTH is in range and STEP is even and below 2^WIDTH.
  // Evaluated in 64 bits so that WIDTH = 32 does not overflow the limit.
  function automatic bit step_is_legal(input int unsigned width,
                                       input int unsigned step);
    longint unsigned lim;
    bit              ok;
    ok  = 1'b1;
    lim = 64'd1;
    if ((width < MIN_WIDTH) || (width > MAX_WIDTH)) begin
      ok = 1'b0;
    end else begin
      lim = 64'd1 << width;
    end
    if ((step % 2) != 0) begin
      ok = 1'b0;
    end
    if (64'(step) >= lim) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage : even_counter_pkg

// File: rtl/day18_even_counter.sv
// Free-running even-number counter: count advances by STEP each clock and
// wraps modulo 2^WIDTH. Bit 0 is a constant 0 and is not stored.
// Optional feature: define EVEN_COUNTER_WRAP_EN to add the registered
// one-cycle wrap pulse output.
module day18_even_counter
  import even_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned STEP  = DEFAULT_STEP
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
`ifdef EVEN_COUNTER_WRAP_EN
  ,
  output logic             wrap
`endif
);

  // Only the upper WIDTH-1 bits carry state; STEP is even, so the stored
  // part advances by STEP/2 modulo 2^(WIDTH-1).
  localparam int unsigned HI_W = WIDTH - 1;
  localparam logic [HI_W-1:0] STEP_HI = HI_W'(STEP >> 1);

  // Reject illegal parameter combinations at elaboration.
  if (!step_is_legal(WIDTH, STEP)) begin : g_bad_params
    $error("day18_even_counter: illegal WIDTH=%0d / STEP=%0d", WIDTH, STEP);
  end

  logic [HI_W-1:0] r_cnt_hi;
  logic [HI_W-1:0] w_next_hi;

`ifdef EVEN_COUNTER_WRAP_EN
  logic [HI_W:0] w_sum_ext;
  logic          w_carry;
  logic          w_wrap_next;
  logic          r_wrap;

  // Extended add keeps the carry out of the top bit for wrap detection.
  assign w_sum_ext = {1'b0, r_cnt_hi} + {1'b0, STEP_HI};
  assign w_next_hi = w_sum_ext[HI_W-1:0];
  assign w_carry   = w_sum_ext[HI_W];

  // Pulse in the cycle the count lands on 0 through wrap-around.
  always_comb begin
    w_wrap_next = 1'b0;
    if (w_carry && (w_next_hi == '0)) begin
      w_wrap_next = 1'b1;
    end
  end

  // Wrap flag register; cleared asynchronously with the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_next;
    end
  end

  assign wrap = r_wrap;
`else
  // Carry out is simply dropped by the natural width of the add.
  assign w_next_hi = r_cnt_hi + STEP_HI;
`endif

  // Count register: asynchronous clear, increments on every clock otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_hi <= '0;
    end else begin
      r_cnt_hi <= w_next_hi;
    end
  end

  assign count = {r_cnt_hi, 1'b0};

endmodule : day18_even_counter

// File: tb/tb_day18_even_counter.sv
// Self-checking bench for day18_even_counter: default build plus WIDTH=3/STEP=2
// and WIDTH=5/STEP=4 instances, checked against the closed-form n*STEP mod 2^W.
module tb_day18_even_counter;

  logic       clk;
  logic       rst;
  logic [3:0] count4;
  logic [2:0] count3;
  logic [4:0] count5;
  logic       wrap4;
  logic       wrap3;
  logic       wrap5;

  int unsigned checks;
  int unsigned errors;
  int unsigned k; // rising edges seen with rst high since the last reset

  day18_even_counter #(.WIDTH(4), .STEP(2)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .count (count4)
`ifdef EVEN_COUNTER_WRAP_EN
    ,
    .wrap  (wrap4)
`endif
  );

  day18_even_counter #(.WIDTH(3), .STEP(2)) u_dut3 (
    .clk   (clk),
    .rst   (rst),
    .count (count3)
`ifdef EVEN_COUNTER_WRAP_EN
    ,
    .wrap  (wrap3)
`endif
  );

  day18_even_counter #(.WIDTH(5), .STEP(4)) u_dut5 (
    .clk   (clk),
    .rst   (rst),
    .count (count5)
`ifdef EVEN_COUNTER_WRAP_EN
    ,
    .wrap  (wrap5)
`endif
  );

`ifndef EVEN_COUNTER_WRAP_EN
  assign wrap4 = 1'b0;
  assign wrap3 = 1'b0;
  assign wrap5 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: after n counted edges the value is n*STEP mod 2^W.
  function automatic logic [31:0] exp_cnt(input int unsigned n,
                                           input int unsigned step,
                                           input int unsigned w);
    longint unsigned prod;
    prod = longint'(n) * longint'(step);
    return 32'(prod % (64'd1 << w));
  endfunction

  function automatic logic [31:0] exp_wrap(input int unsigned n,
                                           input int unsigned step,
                                           input int unsigned w);
    return ((n != 0) && (exp_cnt(n, step, w) == 0)) ? 32'd1 : 32'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check(input string name);
    chk({name, "/cnt4"}, 32'(count4), exp_cnt(k, 2, 4));
    chk({name, "/cnt3"}, 32'(count3), exp_cnt(k, 2, 3));
    chk({name, "/cnt5"}, 32'(count5), exp_cnt(k, 4, 5));
`ifdef EVEN_COUNTER_WRAP_EN
    chk({name, "/wrap4"}, 32'(wrap4), exp_wrap(k, 2, 4));
    chk({name, "/wrap3"}, 32'(wrap3), exp_wrap(k, 2, 3));
    chk({name, "/wrap5"}, 32'(wrap5), exp_wrap(k, 4, 5));
`endif
  endtask

  // Drive rst on the falling edge, well away from the active edge.
  task automatic set_rst(input logic v);
    @(negedge clk);
    rst = v;
    if (!v) k = 0;
  endtask

  // Advance one rising edge and move the sample point just past it.
  task automatic tick();
    @(posedge clk);
    if (rst) k++;
    else     k = 0;
    #1;
  endtask

  typedef struct {
    logic       rst_in;
    logic [3:0] exp_count;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[16];
  int   budget;

  initial begin
    vecs = '{
      '{1'b1, 4'd2,  1'b0}, '{1'b1, 4'd4,  1'b0}, '{1'b1, 4'd6,  1'b0},
      '{1'b1, 4'd8,  1'b0}, '{1'b1, 4'd10, 1'b0}, '{1'b1, 4'd12, 1'b0},
      '{1'b1, 4'd14, 1'b0}, '{1'b1, 4'd0,  1'b1}, '{1'b1, 4'd2,  1'b0},
      '{1'b1, 4'd4,  1'b0}, '{1'b1, 4'd6,  1'b0}, '{1'b1, 4'd8,  1'b0},
      '{1'b1, 4'd10, 1'b0}, '{1'b1, 4'd12, 1'b0}, '{1'b1, 4'd14, 1'b0},
      '{1'b1, 4'd0,  1'b1}
    };
    checks = 0;
    errors = 0;
    k      = 0;
    rst    = 1'b0;

    // Reset state, no clock edge needed.
    #1;
    chk("reset_t0_cnt4", 32'(count4), 32'd0);
    model_check("reset_t0");

    // Held in reset across several edges.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold_cnt4", 32'(count4), 32'd0);
      model_check("reset_hold");
    end

    // Release and run two full wrap periods from the table.
    for (int i = 0; i < 16; i++) begin
      set_rst(vecs[i].rst_in);
      tick();
      chk($sformatf("vec%0d_cnt4", i), 32'(count4), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_bit0", i), 32'(count4[0]), 32'd0);
`ifdef EVEN_COUNTER_WRAP_EN
      chk($sformatf("vec%0d_wrap4", i), 32'(wrap4), 32'(vecs[i].exp_wrap));
`endif
      model_check($sformatf("vec%0d", i));
    end

    // Run up to count = 10, then clear asynchronously between edges.
    budget = 20;
    while ((count4 != 4'd10) && (budget > 0)) begin
      tick();
      model_check("to_ten");
      budget--;
    end
    chk("reach_ten_budget", 32'(budget != 0), 32'd1);
    #2;
    rst = 1'b0;
    k   = 0;
    #1;
    chk("async_clear_cnt4", 32'(count4), 32'd0);
    model_check("async_clear");
    tick();
    chk("async_hold_cnt4", 32'(count4), 32'd0);
    set_rst(1'b1);
    tick();
    chk("resume1_cnt4", 32'(count4), 32'd2);
`ifdef EVEN_COUNTER_WRAP_EN
    chk("resume1_wrap4", 32'(wrap4), 32'd0);
`endif
    tick();
    chk("resume2_cnt4", 32'(count4), 32'd4);
    model_check("resume2");

    // Random reset activity, synchronous-release and mid-cycle async clears.
    for (int i = 0; i < 400; i++) begin
      set_rst(($urandom_range(0, 19) != 0) ? 1'b1 : 1'b0);
      tick();
      model_check("rand");
      if (rst && ($urandom_range(0, 29) == 0)) begin
        #1;
        rst = 1'b0;
        k   = 0;
        #1;
        model_check("rand_async");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_day18_even_counter
